// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        FAULT   = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_STEP = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

    localparam int unsigned  PC_INC           = 4;
    localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus between the fetch sequencer and memory.
interface fetch_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_resp_valid;
    logic [31:0]      imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register with hold / +4 / load-target next-PC selection.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  pc_sel_t          i_sel,
    input  logic [WIDTH-1:0] i_target,
    output logic [WIDTH-1:0] o_pc
);

    logic [WIDTH-1:0] r_pc;

    // Increment wraps naturally modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            case (i_sel)
                PC_STEP: r_pc <= r_pc + WIDTH'(PC_INC);
                PC_LOAD: r_pc <= i_target;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: one outstanding imem request, redirect/stall handling.
// Optional macro MISALIGN_TRAP_EN: misaligned redirects trap into a sticky FAULT state.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_stall,
    input  logic                 i_redirect,
    input  logic [WIDTH-1:0]     i_redirect_target,
    fetch_sequencer_if.master    imem,
    output logic                 o_if_valid,
    output logic [31:0]          o_if_instr,
    output logic [WIDTH-1:0]     o_if_pc,
    output logic                 o_misalign
);

    fetch_state_t     r_state;
    logic             r_kill;
    logic             r_req_valid;
    logic             r_if_valid;
    logic [31:0]      r_if_instr;
    logic [WIDTH-1:0] r_if_pc;

    logic [WIDTH-1:0] w_pc;
    logic [WIDTH-1:0] w_target;
    logic             w_trap;
    logic             w_take_redirect;
    logic             w_accept_resp;
    pc_sel_t          w_pc_sel;

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_target   = i_redirect_target;
    assign w_trap     = i_redirect && (i_redirect_target[1:0] != 2'b00) && (r_state != FAULT);
    assign o_misalign = r_misalign;
`else
    // Low address bits are dropped so the PC can never become misaligned.
    assign w_target   = {i_redirect_target[WIDTH-1:2], 2'b00};
    assign w_trap     = 1'b0;
    assign o_misalign = 1'b0;
`endif

    assign w_take_redirect = i_redirect && (r_state != FAULT) && !w_trap;
    assign w_accept_resp   = (r_state == WAIT) && imem.imem_resp_valid && !r_kill && !i_redirect;

    always_comb begin
        w_pc_sel = PC_HOLD;
        if (w_take_redirect) begin
            w_pc_sel = PC_LOAD;
        end else if (w_accept_resp) begin
            w_pc_sel = PC_STEP;
        end
    end

    fetch_pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .i_sel    (w_pc_sel),
        .i_target (w_target),
        .o_pc     (w_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_kill      <= 1'b0;
            r_req_valid <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_instr  <= 32'h0;
            r_if_pc     <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
            r_misalign  <= 1'b0;
`endif
        end else if (w_trap) begin
`ifdef MISALIGN_TRAP_EN
            r_misalign  <= 1'b1;
`endif
            r_state     <= FAULT;
            r_kill      <= 1'b0;
            r_req_valid <= 1'b0;
            r_if_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state     <= REQ;
                    r_req_valid <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_req_ready) begin
                        r_state     <= WAIT;
                        r_req_valid <= 1'b0;
                        r_kill      <= i_redirect;
                    end
                end
                WAIT: begin
                    if (imem.imem_resp_valid) begin
                        if (r_kill || i_redirect) begin
                            r_kill      <= 1'b0;
                            r_state     <= REQ;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_instr <= imem.imem_resp_data;
                            r_if_pc    <= w_pc;
                            r_state    <= PRESENT;
                        end
                    end else if (i_redirect) begin
                        // Response still owed for the old address: mark it for discard.
                        r_kill <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (i_redirect || !i_stall) begin
                        r_if_valid  <= 1'b0;
                        r_state     <= REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req_valid = r_req_valid;
    assign imem.imem_addr      = w_pc;
    assign o_if_valid          = r_if_valid;
    assign o_if_instr          = r_if_instr;
    assign o_if_pc             = r_if_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer; one line printed per vector.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign;

    fetch_sequencer_if #(.WIDTH(32)) bus ();

    fetch_sequencer #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_stall           (stall),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .imem              (bus),
        .o_if_valid        (if_valid),
        .o_if_instr        (if_instr),
        .o_if_pc           (if_pc),
        .o_misalign        (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic        rdy;
        logic        rsv;
        logic [31:0] data;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [31:0] I0 = 32'h0000_0013;
    localparam logic [31:0] I1 = 32'h0010_0093;
    localparam logic [31:0] I2 = 32'h0020_0113;
    localparam logic [31:0] I3 = 32'h0000_0517;
    localparam logic [31:0] I4 = 32'h00A0_0093;
    localparam logic [31:0] I5 = 32'h1111_1111;

    function automatic vec_t mk(string name, logic st, logic rd, logic [31:0] tgt,
                                logic rdy, logic rsv, logic [31:0] data,
                                logic e_rv, logic [31:0] e_addr, logic e_ifv,
                                logic [31:0] e_pc, logic [31:0] e_instr, logic e_mis);
        vec_t v;
        v.name = name; v.st = st; v.rd = rd; v.tgt = tgt; v.rdy = rdy; v.rsv = rsv;
        v.data = data; v.e_rv = e_rv; v.e_addr = e_addr; v.e_ifv = e_ifv;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check_out(string name, logic e_rv, logic [31:0] e_addr, logic e_ifv,
                             logic [31:0] e_pc, logic [31:0] e_instr, logic e_mis);
        logic [97:0] got;
        logic [97:0] exp;
        got = {bus.imem_req_valid, bus.imem_addr, if_valid, if_pc, misalign, 1'b0};
        exp = {e_rv, e_addr, e_ifv, e_pc, e_mis, 1'b0};
        n_checks++;
        if (got == exp && (!e_ifv || if_instr == e_instr) && (name != "reset" || if_instr == e_instr)) begin
            n_pass++;
            $display("ok   %-14s rv=%0b addr=%08h ifv=%0b pc=%08h instr=%08h mis=%0b",
                     name, bus.imem_req_valid, bus.imem_addr, if_valid, if_pc, if_instr, misalign);
        end else begin
            $display("FAIL %-14s got rv=%0b addr=%08h ifv=%0b pc=%08h instr=%08h mis=%0b | exp rv=%0b addr=%08h ifv=%0b pc=%08h instr=%08h mis=%0b",
                     name, bus.imem_req_valid, bus.imem_addr, if_valid, if_pc, if_instr, misalign,
                     e_rv, e_addr, e_ifv, e_pc, e_instr, e_mis);
        end
    endtask

    // Called at a negedge: drive, clock once, then compare just after the edge.
    task automatic apply(vec_t v);
        stall               = v.st;
        redirect            = v.rd;
        redirect_target     = v.tgt;
        bus.imem_req_ready  = v.rdy;
        bus.imem_resp_valid = v.rsv;
        bus.imem_resp_data  = v.data;
        @(posedge clk);
        #1;
        check_out(v.name, v.e_rv, v.e_addr, v.e_ifv, v.e_pc, v.e_instr, v.e_mis);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0;

        // Basic stream, decode stall, and redirect corner cases.
        vecs.push_back(mk("boot_req",   0,0,32'h0,  1,0,32'h0,      1,32'h0,  0,32'h0,  32'h0,0));
        vecs.push_back(mk("acc0",       0,0,32'h0,  1,0,32'h0,      0,32'h0,  0,32'h0,  32'h0,0));
        vecs.push_back(mk("resp0",      0,0,32'h0,  0,1,I0,         0,32'h4,  1,32'h0,  I0,0));
        vecs.push_back(mk("cons0",      0,0,32'h0,  0,0,32'h0,      1,32'h4,  0,32'h0,  I0,0));
        vecs.push_back(mk("acc4",       0,0,32'h0,  1,0,32'h0,      0,32'h4,  0,32'h0,  I0,0));
        vecs.push_back(mk("resp4",      0,0,32'h0,  0,1,I1,         0,32'h8,  1,32'h4,  I1,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("stall",  1,0,32'h0,  1,0,32'h0,      0,32'h8,  1,32'h4,  I1,0));
        vecs.push_back(mk("unstall",    0,0,32'h0,  0,0,32'h0,      1,32'h8,  0,32'h4,  I1,0));
        vecs.push_back(mk("acc8",       0,0,32'h0,  1,0,32'h0,      0,32'h8,  0,32'h4,  I1,0));
        vecs.push_back(mk("redir_wait", 0,1,32'h100,0,0,32'h0,      0,32'h100,0,32'h4,  I1,0));
        vecs.push_back(mk("stale_resp", 0,0,32'h0,  0,1,I2,         1,32'h100,0,32'h4,  I1,0));
        vecs.push_back(mk("acc100",     0,0,32'h0,  1,0,32'h0,      0,32'h100,0,32'h4,  I1,0));
        vecs.push_back(mk("resp100",    0,0,32'h0,  0,1,I3,         0,32'h104,1,32'h100,I3,0));
        vecs.push_back(mk("cons100",    0,0,32'h0,  0,0,32'h0,      1,32'h104,0,32'h100,I3,0));
        vecs.push_back(mk("acc104",     0,0,32'h0,  1,0,32'h0,      0,32'h104,0,32'h100,I3,0));
        vecs.push_back(mk("redir_resp", 0,1,32'h40, 0,1,32'hAAAA5555,1,32'h40,0,32'h100,I3,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("no_ready",0,0,32'h0, 0,0,32'h0,      1,32'h40, 0,32'h100,I3,0));
        vecs.push_back(mk("redir_req",  0,1,32'h20, 0,0,32'h0,      1,32'h20, 0,32'h100,I3,0));
        vecs.push_back(mk("acc20",      0,0,32'h0,  1,0,32'h0,      0,32'h20, 0,32'h100,I3,0));
        vecs.push_back(mk("resp20",     0,0,32'h0,  0,1,I4,         0,32'h24, 1,32'h20, I4,0));
        vecs.push_back(mk("redir_pres", 1,1,32'h80, 0,0,32'h0,      1,32'h80, 0,32'h20, I4,0));
        vecs.push_back(mk("redir_acc",  0,1,32'h200,1,0,32'h0,      0,32'h200,0,32'h20, I4,0));
        vecs.push_back(mk("killed_resp",0,0,32'h0,  0,1,32'hBBBB0000,1,32'h200,0,32'h20,I4,0));
        vecs.push_back(mk("acc200",     0,0,32'h0,  1,0,32'h0,      0,32'h200,0,32'h20, I4,0));
        vecs.push_back(mk("resp200",    0,0,32'h0,  0,1,I5,         0,32'h204,1,32'h200,I5,0));
        vecs.push_back(mk("cons200",    0,0,32'h0,  0,0,32'h0,      1,32'h204,0,32'h200,I5,0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("misalign",   0,1,32'h102,0,0,32'h0,      0,32'h204,0,32'h200,I5,1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("fault_hold",0,1,32'h300,1,1,32'hCCCC0000,0,32'h204,0,32'h200,I5,1));
`else
        vecs.push_back(mk("misalign",   0,1,32'h102,0,0,32'h0,      1,32'h100,0,32'h200,I5,0));
        vecs.push_back(mk("acc_mis",    0,0,32'h0,  1,0,32'h0,      0,32'h100,0,32'h200,I5,0));
`endif

        repeat (3) @(negedge clk);
        check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset in the middle of an outstanding transaction.
        bus.imem_resp_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Late response after reset is ignored; then +4 wraps past the top of memory.
        apply(mk("late_idle", 0,0,32'h0,       0,1,32'hDDDD0000, 1,32'h0,       0,32'h0,       32'h0, 0));
        apply(mk("late_req",  0,1,32'hFFFFFFFC,0,1,32'hDDDD0000, 1,32'hFFFFFFFC,0,32'h0,       32'h0, 0));
        apply(mk("acc_top",   0,0,32'h0,       1,0,32'h0,        0,32'hFFFFFFFC,0,32'h0,       32'h0, 0));
        apply(mk("resp_top",  0,0,32'h0,       0,1,32'h00000073, 0,32'h0,       1,32'hFFFFFFFC,32'h73,0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter and sequences fetches from instruction memory over a valid/ready request and valid response handshake. It accepts branch/jump redirects (target already computed as PC+ImmOp by the datapath) and back-pressure from decode. It presents one registered instruction/PC pair to decode. At most one memory request is outstanding at any time.

Parameters:
WIDTH, 32, PC and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  decode cannot accept the presented instruction
redirect  in  1  take branch/jump this cycle
redirect_target  in  WIDTH  new PC when redirect=1
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  WIDTH  fetch address (= pc_q)
imem_resp_valid  in  1  response data valid (one per accepted request)
imem_resp_data  in  32  fetched instruction
if_valid  out  1  if_instr/if_pc valid to decode
if_instr  out  32  registered instruction
if_pc  out  WIDTH  PC of if_instr
misalign  out  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE, pc_q=RESET_PC, kill=0, if_valid=0, if_instr=0, if_pc=RESET_PC, imem_req_valid=0, misalign=0.
- imem_addr=pc_q always. imem_req_valid=1 only in REQ.
- States: IDLE, REQ, WAIT, PRESENT (plus FAULT with macro).
- IDLE -> REQ on the next cycle, unconditionally. Redirect in IDLE: pc_q<=target.
- REQ:
  - ready=1, redirect=0 -> WAIT.
  - ready=1, redirect=1 -> WAIT with kill<=1, pc_q<=target.
  - ready=0, redirect=1 -> stay REQ, pc_q<=target. The request is withdrawn and the address changes next cycle; memory must tolerate this.
  - ready=0, redirect=0 -> stay REQ, address stable.
- WAIT:
  - resp_valid=1 and (kill=1 or redirect=1) -> discard data, kill<=0, pc_q<=target if redirect, -> REQ.
  - resp_valid=1, kill=0, redirect=0 -> if_instr<=data, if_pc<=pc_q, if_valid<=1, pc_q<=pc_q+4, -> PRESENT.
  - resp_valid=0, redirect=1 -> kill<=1, pc_q<=target, stay WAIT.
- PRESENT (if_valid=1):
  - redirect=1 (priority over stall/consume) -> if_valid<=0, pc_q<=target, -> REQ.
  - stall=0 -> instruction consumed this cycle, if_valid<=0, -> REQ.
  - stall=1 -> hold all outputs.
- Latency: an accepted request whose response arrives one cycle later yields if_valid on the following cycle. Best throughput is one instruction per 3 cycles.
- pc_q+4 wraps modulo 2^WIDTH. Only pc_q+4 or redirect_target ever update pc_q.
- stall never blocks redirect. stall is ignored outside PRESENT.
- Async reset mid-transaction drops the outstanding request. A late response after reset arrives in IDLE/REQ and is ignored.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_target[1:0]!=0 sets misalign<=1 (sticky until reset), clears if_valid, and -> FAULT. FAULT issues no requests, ignores all inputs, and exits only on reset. An outstanding response is discarded.
- Undefined: misalign is tied 0 and redirect_target[1:0] is forced to 2'b00 when loaded into pc_q.

Decomposition:
- Package fetch_pkg: fetch_state_t enum (IDLE, REQ, WAIT, PRESENT, FAULT), PC_INC=4, default RESET_PC constant.
- Sub-module fetch_pc_reg: PC register with async active-low reset to RESET_PC and a next-PC mux (hold / +4 / target).

Test Plan:
- Reset release, ready=1 always, response 1 cycle after accept, stall=0 -> imem_addr 0x0,0x4,0x8; if_pc 0x0,0x4,0x8 with instrs 0x00000013, 0x00100093, 0x00200113; one per 3 cycles.
- stall=1 for 4 cycles while PRESENT at if_pc=0x4 -> if_valid/if_pc/if_instr held; no request issued; fetch of 0x8 begins the cycle after stall drops.
- redirect to 0x100 in WAIT (request 0x8 outstanding) -> response for 0x8 discarded (if_valid stays 0), next request addr=0x100, if_pc=0x100.
- redirect to 0x40 coincident with resp_valid in WAIT -> data dropped, next imem_addr=0x40.
- ready held 0 for 3 cycles in REQ -> imem_req_valid=1 with addr stable. redirect to 0x20 then -> addr=0x20 next cycle.
- redirect_target=0x102 -> with MISALIGN_TRAP_EN: misalign=1, no further requests until rst=0. Without it: imem_addr=0x100, misalign=0.
